// File: rtl/soc_event_generator.sv
// ============================================================================
//  Module   : soc_event_generator
//  Purpose  : Counts masked SoC event pulses per line and streams one event ID
//             per pending occurrence on a valid/ready interface, round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_event_generator #(
    parameter int NB_EVT     = 32,
    parameter int EVNT_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_EVT-1:0]     evt_i,
    input  logic [NB_EVT-1:0]     evt_mask_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [EVNT_WIDTH-1:0] evt_data_o,
    output logic                  evt_overflow_o,
    output logic                  pending_o
);

    localparam int                  PTR_W     = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [PTR_W:0]      C_NB      = (PTR_W+1)'(NB_EVT);
    localparam logic [PTR_W-1:0]    C_LAST    = PTR_W'(NB_EVT - 1);

    logic [NB_EVT-1:0]     w_req;
    logic [NB_EVT-1:0]     w_drop;
    logic                  w_any_req;
    logic                  w_load;
    logic                  w_gnt_vld;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W:0]        w_pos;
    logic [PTR_W-1:0]      w_ptr_d;

    logic [PTR_W-1:0]      ptr_q;
    logic                  valid_q;
    logic [EVNT_WIDTH-1:0] data_q;
    logic                  ovf_q;

    assign w_any_req = |w_req;
    assign w_load    = (~valid_q | evt_ready_i) & w_any_req;

    // Per-line saturating pending counters
    generate
        for (genvar k = 0; k < NB_EVT; k++) begin : g_line
            logic [CNT_WIDTH-1:0] cnt_q;
            logic [CNT_WIDTH-1:0] cnt_d;
            logic                 w_inc;
            logic                 w_dec;

            assign w_inc     = evt_i[k] & evt_mask_i[k];
            assign w_dec     = w_load & (w_gnt_idx == PTR_W'(k));
            assign w_req[k]  = |cnt_q;
            assign w_drop[k] = w_inc & ~w_dec & (cnt_q == C_CNT_MAX);

            always_comb begin
                cnt_d = cnt_q;
                if (w_inc && !w_dec && (cnt_q != C_CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (w_dec && !w_inc) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Search upward from the pointer, wrapping at NB_EVT-1; first hit wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_pos     = '0;
        for (int i = 0; i < NB_EVT; i++) begin
            w_pos = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (w_pos >= C_NB) begin
                w_pos = w_pos - C_NB;
            end
            if (!w_gnt_vld && w_req[w_pos[PTR_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_pos[PTR_W-1:0];
            end
        end
    end

    assign w_ptr_d = (w_gnt_idx == C_LAST) ? '0 : (w_gnt_idx + 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= |w_drop;
            if (w_load && w_gnt_vld) begin
                valid_q <= 1'b1;
                data_q  <= EVNT_WIDTH'(w_gnt_idx);
                ptr_q   <= w_ptr_d;
            end else if (valid_q && evt_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign evt_valid_o    = valid_q;
    assign evt_data_o     = data_q;
    assign evt_overflow_o = ovf_q;
    assign pending_o      = w_any_req | valid_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_event_generator.sv
// ============================================================================
//  Module   : tb_soc_event_generator
//  Purpose  : Directed and randomized checks of soc_event_generator against a
//             queue/array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_event_generator;

    localparam int NB   = 32;
    localparam int EW   = 8;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] evt;
    logic [NB-1:0] mask;
    logic          ready;
    logic          valid;
    logic [EW-1:0] data;
    logic          ovf;
    logic          pend;

    always #5 clk = ~clk;

    soc_event_generator #(
        .NB_EVT    (NB),
        .EVNT_WIDTH(EW),
        .CNT_WIDTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .evt_i         (evt),
        .evt_mask_i    (mask),
        .evt_valid_o   (valid),
        .evt_ready_i   (ready),
        .evt_data_o    (data),
        .evt_overflow_o(ovf),
        .pending_o     (pend)
    );

    int checks = 0;
    int errors = 0;

    int m_cnt [NB];
    int m_ptr;
    bit m_valid;
    int m_data;
    bit m_ovf;

    int sent  [$];
    int exp_q [$];
    int ovf_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_pending();
        bit p = m_valid;
        foreach (m_cnt[k]) if (m_cnt[k] != 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs being applied.
    task automatic model_step();
        int gnt = -1;
        bit load;
        bit drop = 1'b0;
        for (int i = 0; i < NB; i++) begin
            int k = (m_ptr + i) % NB;
            if (gnt < 0 && m_cnt[k] != 0) gnt = k;
        end
        load = (!m_valid || ready) && (gnt >= 0);
        for (int k = 0; k < NB; k++) begin
            bit inc = evt[k] && mask[k];
            bit dec = load && (k == gnt);
            if (inc && !dec) begin
                if (m_cnt[k] == MAXC) drop = 1'b1;
                else m_cnt[k]++;
            end else if (dec && !inc) begin
                m_cnt[k]--;
            end
        end
        if (load) begin
            m_valid = 1'b1;
            m_data  = gnt;
            m_ptr   = (gnt + 1) % NB;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        m_ovf = drop;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data", 32'(data), 32'(m_data));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("pending", 32'(pend), 32'(m_pending()));
        if (ovf === 1'b1) ovf_seen++;
    endtask

    task automatic cycle(input logic [NB-1:0] e, input logic [NB-1:0] m, input logic r);
        @(negedge clk);
        evt   = e;
        mask  = m;
        ready = r;
        if (valid === 1'b1 && ready) sent.push_back(int'(data));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle('0, '1, r);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_pending"}, 32'(pend), 32'd0);
        model_reset();
        @(negedge clk);
        evt   = '0;
        rst_n = 1'b1;
        sent.delete();
        ovf_seen = 0;
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_count"}, 32'(sent.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
            chk(tag, 32'(sent[i]), 32'(exp_q[i]));
        sent.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        evt   = '0;
        mask  = '1;
        ready = 1'b0;
        ovf_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_pending", 32'(pend), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse on line 5
        cycle(NB'(1) << 5, '1, 1'b1);
        chk("single_not_yet", 32'(valid), 32'd0);
        idle(3, 1'b1);
        chk("single_pending_clear", 32'(pend), 32'd0);
        exp_q = '{5};
        chk_seq("single_seq");

        // Round-robin from pointer 0, then wrap from 31
        async_reset("rst_rr");
        cycle((NB'(1) << 3) | (NB'(1) << 7) | (NB'(1) << 30), '1, 1'b1);
        idle(5, 1'b1);
        exp_q = '{3, 7, 30};
        chk_seq("rr_seq1");
        cycle((NB'(1) << 3) | (NB'(1) << 30), '1, 1'b1);
        idle(4, 1'b1);
        exp_q = '{3, 30};
        chk_seq("rr_seq2");

        // Backpressure
        async_reset("rst_bp");
        cycle((NB'(1) << 2) | (NB'(1) << 9), '1, 1'b0);
        cycle(NB'(1) << 2, '1, 1'b0);
        cycle(NB'(1) << 2, '1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle('0, '1, 1'b0);
            chk("bp_hold_valid", 32'(valid), 32'd1);
            chk("bp_hold_data", 32'(data), 32'd2);
        end
        idle(6, 1'b1);
        exp_q = '{2, 9, 2, 2};
        chk_seq("bp_seq");

        // Saturation on line 1
        async_reset("rst_sat");
        for (int i = 0; i < 17; i++) cycle(NB'(1) << 1, '1, 1'b0);
        idle(2, 1'b0);
        chk("sat_ovf_pulses", 32'(ovf_seen), 32'd1);
        idle(20, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(1);
        chk_seq("sat_seq");

        // Simultaneous inc/dec and masking on line 4
        async_reset("rst_mask");
        for (int i = 0; i < 3; i++) cycle(NB'(1) << 4, '1, 1'b0);
        cycle(NB'(1) << 4, '1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(NB'(1) << 4, ~(NB'(1) << 4), 1'b1);
        exp_q = '{4, 4, 4, 4};
        chk_seq("mask_seq");
        chk("mask_pending_clear", 32'(pend), 32'd0);

        // Reset in the middle of a held transfer
        async_reset("rst_pre");
        cycle((NB'(1) << 6) | (NB'(1) << 12), '1, 1'b0);
        cycle(NB'(1) << 6, '1, 1'b0);
        cycle('0, '1, 1'b0);
        chk("mid_valid_before", 32'(valid), 32'd1);
        async_reset("rst_mid");
        idle(10, 1'b1);
        chk("mid_nothing_sent", 32'(sent.size()), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [NB-1:0] e;
            logic          r;
            if (i < 300) e = NB'($urandom & $urandom & $urandom);
            else         e = NB'($urandom & $urandom);
            r = ($urandom_range(0, 3) != 0);
            cycle(e, NB'($urandom | $urandom), r);
        end
        idle(NB * (MAXC + 1) + 8, 1'b1);
        chk("drain_pending", 32'(pend), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
